// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: serial program loader and CPU reset sequencer.
// Holds the CPU in reset, receives a framed image
// (SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, data..., CHK) from a UART byte
// receiver, writes the data bytes to memory, checks the 8-bit modulo sum of
// the data bytes, replies ACK/NAK, and on ACK releases CPU reset after a hold.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rx_data, rx_valid     received byte and its single-cycle strobe
//   tx_data, tx_valid     reply byte, held until tx_ready
//   tx_ready              transmitter accepts when tx_valid & tx_ready
//   mem_addr, mem_wdata   memory write address / data
//   mem_we                one-cycle write strobe per data byte
//   cpu_reset             active-high CPU reset
//   boot_req              re-enter load mode from RUN
//   busy                  high in every state except RUN
//   error                 sticky NAK flag, cleared by the next SYNC byte
module boot_loader_ctrl #(
    parameter int unsigned ADDR_W     = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [7:0]  ACK_BYTE   = 8'h06,
    parameter logic [7:0]  NAK_BYTE   = 8'h15,
    parameter int unsigned RESET_HOLD = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              cpu_reset,
    input  logic              boot_req,
    output logic              busy,
    output logic              error
);

    localparam int unsigned TO_W   = $clog2(TIMEOUT);
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int unsigned LEN_W  = 16;

    typedef enum logic [3:0] {
        S_HOLD,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_CHK,
        S_RESP,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic [TO_W-1:0]     idle_q, idle_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                ack_q, ack_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_HOLD;
            addr_q      <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            idle_q      <= '0;
            hold_q      <= '0;
            ack_q       <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            idle_q      <= idle_d;
            hold_q      <= hold_d;
            ack_q       <= ack_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        sum_d       = sum_q;
        idle_d      = '0;
        hold_d      = '0;
        ack_d       = ack_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_reset_d = cpu_reset_q;
        error_d     = error_q;

        unique case (state_q)
            S_HOLD: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = S_ADDR_H;
                    error_d = 1'b0;
                    sum_d   = '0;
                end
            end

            S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CHK: begin
                if (rx_valid) begin
                    case (state_q)
                        S_ADDR_H: begin
                            addr_d  = ADDR_W'({rx_data, 8'h00});
                            state_d = S_ADDR_L;
                        end
                        S_ADDR_L: begin
                            addr_d  = addr_q | ADDR_W'(rx_data);
                            state_d = S_LEN_H;
                        end
                        S_LEN_H: begin
                            len_d   = {rx_data, 8'h00};
                            state_d = S_LEN_L;
                        end
                        S_LEN_L: begin
                            len_d   = {len_q[15:8], rx_data};
                            state_d = ({len_q[15:8], rx_data} == 16'h0000) ? S_CHK : S_DATA;
                        end
                        S_DATA: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_q;
                            mem_wdata_d = rx_data;
                            addr_d      = addr_q + ADDR_W'(1);
                            sum_d       = sum_q + rx_data;
                            len_d       = len_q - 16'd1;
                            if (len_q == 16'd1) begin
                                state_d = S_CHK;
                            end
                        end
                        S_CHK: begin
                            ack_d      = (rx_data == sum_q);
                            tx_data_d  = (rx_data == sum_q) ? ACK_BYTE : NAK_BYTE;
                            tx_valid_d = 1'b1;
                            state_d    = S_RESP;
                        end
                        default: ;
                    endcase
                end else if (idle_q == TO_W'(TIMEOUT - 1)) begin
                    // Inter-byte gap too long: abort with NAK; written data stays.
                    ack_d      = 1'b0;
                    tx_data_d  = NAK_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end

            S_RESP: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (ack_q) begin
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_HOLD;
                        error_d = 1'b1;
                    end
                end
            end

            // hold_q counts edges since the handshake; reset drops on the last.
            S_RELEASE: begin
                if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
                    cpu_reset_d = 1'b0;
                    state_d     = S_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            S_RUN: begin
                if (boot_req) begin
                    cpu_reset_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end

            default: begin
                state_d = S_HOLD;
            end
        endcase

        busy_d = (state_d != S_RUN);
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule
